// File: rtl/pulse_synth.sv
// Event-driven pulse generator: replays bus-queued {t0, t1, amp, type} records
// as rectangular pulses on DAC channel A (alpha) or B (gamma).
module pulse_synth #(
   parameter int FIFO_DEPTH = 16,
   parameter int LVL_W      = 9
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   output logic [13:0] dat_a_o,
   output logic [13:0] dat_b_o,
   input  logic [31:0] sys_addr,
   input  logic [31:0] sys_wdata,
   input  logic [3:0]  sys_sel,
   input  logic        sys_wen,
   input  logic        sys_ren,
   output logic [31:0] sys_rdata,
   output logic        sys_err,
   output logic        sys_ack
);

   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int ENT_W = 63;

   localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(FIFO_DEPTH);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_LOAD  = 2'd1;
   localparam logic [1:0] S_GAP   = 2'd2;
   localparam logic [1:0] S_PULSE = 2'd3;

   localparam logic [19:0] A_STG_AMP = 20'h00000;
   localparam logic [19:0] A_STG_T0  = 20'h00004;
   localparam logic [19:0] A_STG_T1  = 20'h00008;
   localparam logic [19:0] A_CTRL    = 20'h0000C;
   localparam logic [19:0] A_LEVEL   = 20'h00010;
   localparam logic [19:0] A_OVF     = 20'h00014;
   localparam logic [19:0] A_EMIT    = 20'h00018;
   localparam logic [19:0] A_BASE    = 20'h0001C;

   logic [19:0] addr;

   logic        stg_type_q, stg_type_d;
   logic [13:0] stg_amp_q, stg_amp_d;
   logic [31:0] stg_t0_q, stg_t0_d;
   logic [15:0] stg_t1_q, stg_t1_d;
   logic        enable_q, enable_d;
   logic        clear_q, clear_d;
   logic [13:0] baseline_q, baseline_d;

   logic [LVL_W-1:0] level_q, level_d;
   logic [LVL_W-1:0] max_level_q, max_level_d;
   logic [31:0]      ovf_cnt_q, ovf_cnt_d;
   logic [31:0]      emit_cnt_q, emit_cnt_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;

   logic [1:0]  state_q, state_d;
   logic [31:0] gap_cnt_q, gap_cnt_d;
   logic [15:0] width_cnt_q, width_cnt_d;
   logic        cur_type_q, cur_type_d;
   logic [13:0] cur_amp_q, cur_amp_d;

   logic [13:0] dat_a_q, dat_a_d;
   logic [13:0] dat_b_q, dat_b_d;
   logic        ack_q, ack_d;
   logic [31:0] rdata_q, rdata_d;

   logic             push_req;
   logic             push_ok;
   logic             ovf_inc;
   logic             pop;
   logic             full;
   logic             emit_inc;
   logic [ENT_W-1:0] push_ent;
   logic [ENT_W-1:0] head;
   logic             head_type;
   logic [13:0]      head_amp;
   logic [31:0]      head_t0;
   logic [15:0]      head_t1;
   logic [15:0]      level_ext;
   logic [15:0]      max_level_ext;

   logic [ENT_W-1:0] mem [FIFO_DEPTH];

   logic unused_bits;

   assign addr          = sys_addr[19:0];
   assign unused_bits   = ^{sys_sel, sys_addr[31:20]};
   assign full          = (level_q == DEPTH_LVL);
   assign push_ok       = push_req && !clear_q && !full;
   assign ovf_inc       = push_req && !clear_q && full;
   assign pop           = (state_q == S_LOAD) && (level_q != '0);
   assign push_ent      = {stg_type_q, stg_amp_q, stg_t0_q, sys_wdata[15:0]};
   assign head          = mem[rd_ptr_q];
   assign head_type     = head[62];
   assign head_amp      = head[61:48];
   assign head_t0       = head[47:16];
   assign head_t1       = head[15:0];
   assign level_ext     = 16'(level_q);
   assign max_level_ext = 16'(max_level_q);

   // Bus writes land in the staging/control registers; writing t1 also pushes the record.
   always_comb begin
      stg_type_d = stg_type_q;
      stg_amp_d  = stg_amp_q;
      stg_t0_d   = stg_t0_q;
      stg_t1_d   = stg_t1_q;
      enable_d   = enable_q;
      baseline_d = baseline_q;
      clear_d    = 1'b0;
      push_req   = 1'b0;
      if (sys_wen) begin
         case (addr)
            A_STG_AMP: begin
               stg_type_d = sys_wdata[14];
               stg_amp_d  = sys_wdata[13:0];
            end
            A_STG_T0:  stg_t0_d = sys_wdata;
            A_STG_T1: begin
               stg_t1_d = sys_wdata[15:0];
               push_req = 1'b1;
            end
            A_CTRL: begin
               enable_d = sys_wdata[0];
               clear_d  = sys_wdata[1];
            end
            A_BASE:    baseline_d = sys_wdata[13:0];
            default:   ;
         endcase
      end
   end

   // Full is judged on the registered level, so a push into a full FIFO drops
   // even when the FSM pops in the same cycle.
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      level_d     = level_q;
      max_level_d = max_level_q;
      ovf_cnt_d   = ovf_cnt_q;
      emit_cnt_d  = emit_cnt_q;
      if (clear_q) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         level_d     = '0;
         max_level_d = '0;
         ovf_cnt_d   = '0;
         emit_cnt_d  = '0;
      end else begin
         if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
         case ({push_ok, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
         endcase
         if (level_d > max_level_q) max_level_d = level_d;
         if (ovf_inc)  ovf_cnt_d  = ovf_cnt_q + 32'd1;
         if (emit_inc) emit_cnt_d = emit_cnt_q + 32'd1;
      end
   end

   // Event sequencer; clear overrides everything and parks the FSM in IDLE.
   always_comb begin
      state_d     = state_q;
      gap_cnt_d   = gap_cnt_q;
      width_cnt_d = width_cnt_q;
      cur_type_d  = cur_type_q;
      cur_amp_d   = cur_amp_q;
      emit_inc    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (enable_q && (level_q != '0)) state_d = S_LOAD;
         end
         S_LOAD: begin
            cur_type_d  = head_type;
            cur_amp_d   = head_amp;
            gap_cnt_d   = head_t0;
            width_cnt_d = head_t1;
            state_d     = (head_t0 != 32'd0) ? S_GAP : S_PULSE;
         end
         S_GAP: begin
            gap_cnt_d = gap_cnt_q - 32'd1;
            if (gap_cnt_q == 32'd1) state_d = S_PULSE;
         end
         S_PULSE: begin
            if (width_cnt_q == 16'd0) begin
               emit_inc = 1'b1;
               state_d  = (enable_q && (level_q != '0)) ? S_LOAD : S_IDLE;
            end else begin
               width_cnt_d = width_cnt_q - 16'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (clear_q) begin
         state_d  = S_IDLE;
         emit_inc = 1'b0;
      end
   end

   // Output samples follow the next state so the first pulse sample appears right after LOAD.
   always_comb begin
      dat_a_d = baseline_d;
      dat_b_d = baseline_d;
      if (state_d == S_PULSE) begin
         if (cur_type_d) dat_b_d = cur_amp_d;
         else            dat_a_d = cur_amp_d;
      end
   end

   always_comb begin
      ack_d   = sys_wen | sys_ren;
      rdata_d = 32'd0;
      if (sys_ren) begin
         case (addr)
            A_STG_AMP: rdata_d = {17'd0, stg_type_q, stg_amp_q};
            A_STG_T0:  rdata_d = stg_t0_q;
            A_STG_T1:  rdata_d = {16'd0, stg_t1_q};
            A_CTRL:    rdata_d = {31'd0, enable_q};
            A_LEVEL:   rdata_d = {max_level_ext, level_ext};
            A_OVF:     rdata_d = ovf_cnt_q;
            A_EMIT:    rdata_d = emit_cnt_q;
            A_BASE:    rdata_d = {18'd0, baseline_q};
            default:   rdata_d = 32'd0;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) mem[wr_ptr_q] <= push_ent;
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         stg_type_q  <= 1'b0;
         stg_amp_q   <= '0;
         stg_t0_q    <= '0;
         stg_t1_q    <= '0;
         enable_q    <= 1'b0;
         clear_q     <= 1'b0;
         baseline_q  <= '0;
         level_q     <= '0;
         max_level_q <= '0;
         ovf_cnt_q   <= '0;
         emit_cnt_q  <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         state_q     <= S_IDLE;
         gap_cnt_q   <= '0;
         width_cnt_q <= '0;
         cur_type_q  <= 1'b0;
         cur_amp_q   <= '0;
         dat_a_q     <= '0;
         dat_b_q     <= '0;
         ack_q       <= 1'b0;
         rdata_q     <= '0;
      end else begin
         stg_type_q  <= stg_type_d;
         stg_amp_q   <= stg_amp_d;
         stg_t0_q    <= stg_t0_d;
         stg_t1_q    <= stg_t1_d;
         enable_q    <= enable_d;
         clear_q     <= clear_d;
         baseline_q  <= baseline_d;
         level_q     <= level_d;
         max_level_q <= max_level_d;
         ovf_cnt_q   <= ovf_cnt_d;
         emit_cnt_q  <= emit_cnt_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         state_q     <= state_d;
         gap_cnt_q   <= gap_cnt_d;
         width_cnt_q <= width_cnt_d;
         cur_type_q  <= cur_type_d;
         cur_amp_q   <= cur_amp_d;
         dat_a_q     <= dat_a_d;
         dat_b_q     <= dat_b_d;
         ack_q       <= ack_d;
         rdata_q     <= rdata_d;
      end
   end

   assign dat_a_o   = dat_a_q;
   assign dat_b_o   = dat_b_q;
   assign sys_ack   = ack_q;
   assign sys_rdata = rdata_q;
   assign sys_err   = 1'b0;

endmodule

// File: tb/tb_pulse_synth.sv
// Self-checking bench for pulse_synth: register table, directed corner cases and
// randomized event streams compared against a per-cycle waveform model.
module tb_pulse_synth;

   localparam logic [31:0] A_AMP  = 32'h00;
   localparam logic [31:0] A_T0   = 32'h04;
   localparam logic [31:0] A_T1   = 32'h08;
   localparam logic [31:0] A_CTRL = 32'h0C;
   localparam logic [31:0] A_LVL  = 32'h10;
   localparam logic [31:0] A_OVF  = 32'h14;
   localparam logic [31:0] A_EMIT = 32'h18;
   localparam logic [31:0] A_BASE = 32'h1C;
   localparam int DEPTH = 16;

   typedef struct {
      bit          isWrite;
      logic [31:0] addr;
      logic [31:0] data;
   } regVec_t;

   typedef struct {
      bit          typ;
      logic [13:0] amp;
      logic [31:0] t0;
      logic [15:0] t1;
   } ev_t;

   logic        clk_i = 1'b0;
   logic        rstn_i;
   logic [13:0] dat_a_o, dat_b_o;
   logic [31:0] sys_addr, sys_wdata, sys_rdata;
   logic [3:0]  sys_sel;
   logic        sys_wen, sys_ren, sys_err, sys_ack;

   int errCount = 0;
   int checkCount = 0;

   ev_t         modelQ[$];
   int          modelMax = 0;
   int          modelOvf = 0;
   int          modelEmit = 0;
   logic [13:0] curBase = 14'd0;
   logic [27:0] expQ[$];
   logic [27:0] capQ[$];
   bit          capOn = 1'b0;

   pulse_synth #(.FIFO_DEPTH(DEPTH), .LVL_W(9)) dut (
      .clk_i(clk_i), .rstn_i(rstn_i), .dat_a_o(dat_a_o), .dat_b_o(dat_b_o),
      .sys_addr(sys_addr), .sys_wdata(sys_wdata), .sys_sel(sys_sel),
      .sys_wen(sys_wen), .sys_ren(sys_ren), .sys_rdata(sys_rdata),
      .sys_err(sys_err), .sys_ack(sys_ack)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) begin
      #1;
      if (capOn) capQ.push_back({dat_a_o, dat_b_o});
   end

   task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic tick(int n);
      repeat (n) @(negedge clk_i);
   endtask

   task automatic busWrite(logic [31:0] a, logic [31:0] d);
      sys_addr = a; sys_wdata = d; sys_wen = 1'b1;
      @(negedge clk_i);
      sys_wen = 1'b0;
   endtask

   task automatic busRead(logic [31:0] a, output logic [31:0] d);
      sys_addr = a; sys_ren = 1'b1;
      @(negedge clk_i);
      sys_ren = 1'b0;
      d = sys_rdata;
      checkOutput("ack", {31'd0, sys_ack}, 32'd1);
   endtask

   task automatic applyStimulus(regVec_t v, int idx);
      logic [31:0] r;
      if (v.isWrite) begin
         busWrite(v.addr, v.data);
         tick(1);
      end else begin
         busRead(v.addr, r);
         checkOutput($sformatf("reg_vec%0d", idx), r, v.data);
      end
   endtask

   function automatic ev_t mkEv(bit typ, logic [13:0] amp, logic [31:0] t0, logic [15:0] t1);
      ev_t e;
      e.typ = typ; e.amp = amp; e.t0 = t0; e.t1 = t1;
      return e;
   endfunction

   function automatic logic [27:0] sampleOf(bit active, ev_t e);
      if (!active) return {curBase, curBase};
      return e.typ ? {curBase, e.amp} : {e.amp, curBase};
   endfunction

   task automatic modelClear();
      modelQ.delete();
      modelMax = 0; modelOvf = 0; modelEmit = 0;
   endtask

   task automatic pushEvent(ev_t e);
      busWrite(A_AMP, {17'd0, e.typ, e.amp});
      busWrite(A_T0, e.t0);
      busWrite(A_T1, {16'hDEAD, e.t1});
      if (modelQ.size() == DEPTH) modelOvf++;
      else begin
         modelQ.push_back(e);
         if (modelQ.size() > modelMax) modelMax = modelQ.size();
      end
   endtask

   task automatic setBase(logic [13:0] b);
      busWrite(A_BASE, {18'h3FFFF, b});
      curBase = b;
   endtask

   task automatic doClear();
      busWrite(A_CTRL, 32'h2);
      tick(1);
      modelClear();
   endtask

   // Expected output, one sample per cycle starting with the first LOAD cycle.
   task automatic startRun(int nPop);
      ev_t e;
      expQ.delete();
      for (int i = 0; i < nPop; i++) begin
         e = modelQ.pop_front();
         expQ.push_back(sampleOf(1'b0, e));
         for (int g = 0; g < int'(e.t0); g++) expQ.push_back(sampleOf(1'b0, e));
         for (int w = 0; w <= int'(e.t1); w++) expQ.push_back(sampleOf(1'b1, e));
         modelEmit++;
      end
      for (int i = 0; i < 4; i++) expQ.push_back(sampleOf(1'b0, e));
      busWrite(A_CTRL, 32'h1);
      capQ.delete();
      capOn = 1'b1;
   endtask

   task automatic finishRun(string name);
      int guard = 0;
      int mism = 0;
      int first = -1;
      while (capQ.size() < expQ.size() && guard < 5000) begin
         @(negedge clk_i);
         guard++;
      end
      capOn = 1'b0;
      for (int i = 0; i < expQ.size(); i++) begin
         if (i >= capQ.size() || capQ[i] !== expQ[i]) begin
            mism++;
            if (first < 0) first = i;
         end
      end
      if (first >= 0)
         $display("[TB] %s first difference at sample %0d of %0d", name, first, expQ.size());
      checkOutput({name, "_wave_mism"}, mism, 0);
      busWrite(A_CTRL, 32'h0);
   endtask

   task automatic checkStats(string name);
      logic [31:0] r;
      busRead(A_LVL, r);
      checkOutput({name, "_level"}, r, {16'(modelMax), 16'(modelQ.size())});
      busRead(A_OVF, r);
      checkOutput({name, "_ovf"}, r, modelOvf);
      busRead(A_EMIT, r);
      checkOutput({name, "_emit"}, r, modelEmit);
   endtask

   regVec_t vecs [25];

   initial begin
      logic [31:0] r;
      int k;
      vecs = '{
         '{1'b0, A_AMP,  32'h0},       '{1'b0, A_T0,   32'h0},
         '{1'b0, A_T1,   32'h0},       '{1'b0, A_CTRL, 32'h0},
         '{1'b0, A_LVL,  32'h0},       '{1'b0, A_OVF,  32'h0},
         '{1'b0, A_EMIT, 32'h0},       '{1'b0, A_BASE, 32'h0},
         '{1'b0, 32'h20, 32'h0},
         '{1'b1, A_AMP,  32'hFFFFFFFF}, '{1'b0, A_AMP,  32'h00007FFF},
         '{1'b1, A_T0,   32'h12345678}, '{1'b0, A_T0,   32'h12345678},
         '{1'b1, A_BASE, 32'hFFFFA5A5}, '{1'b0, A_BASE, 32'h000025A5},
         '{1'b1, A_T1,   32'hFFFFABCD}, '{1'b0, A_T1,   32'h0000ABCD},
         '{1'b0, A_LVL,  32'h00010001},
         '{1'b1, A_CTRL, 32'h2},        '{1'b0, A_CTRL, 32'h0},
         '{1'b0, A_LVL,  32'h0},        '{1'b0, A_AMP,  32'h00007FFF},
         '{1'b0, 32'hFFF0001C, 32'h000025A5},
         '{1'b1, 32'h40, 32'hFFFFFFFF}, '{1'b0, 32'h40, 32'h0}
      };

      rstn_i = 1'b0; sys_addr = '0; sys_wdata = '0; sys_sel = 4'hF;
      sys_wen = 1'b0; sys_ren = 1'b0;
      tick(2);
      checkOutput("rst_dat_a", {18'd0, dat_a_o}, 32'd0);
      checkOutput("rst_dat_b", {18'd0, dat_b_o}, 32'd0);
      checkOutput("rst_ack", {31'd0, sys_ack}, 32'd0);
      checkOutput("rst_rdata", sys_rdata, 32'd0);
      rstn_i = 1'b1;
      tick(1);

      for (int i = 0; i < 25; i++) applyStimulus(vecs[i], i);
      checkOutput("err_const", {31'd0, sys_err}, 32'd0);

      // Single alpha pulse, 4 cycles wide, right after LOAD.
      setBase(14'h0100);
      pushEvent(mkEv(1'b0, 14'h1000, 32'd0, 16'd3));
      checkStats("t1_pre");
      startRun(1);
      finishRun("t1");
      checkStats("t1_post");

      // Gamma pulse with a 10-cycle gap and a negative amplitude.
      pushEvent(mkEv(1'b1, 14'h3830, 32'd10, 16'd0));
      startRun(1);
      finishRun("t2");
      checkStats("t2_post");

      // Overfill the FIFO, then drain it.
      for (int i = 0; i < DEPTH + 3; i++)
         pushEvent(mkEv(i[0], 14'h0200 + 14'(i), 32'd0, 16'd0));
      checkStats("t3_full");
      startRun(DEPTH);
      finishRun("t3");
      checkStats("t3_drained");

      // Clear during a long pulse.
      pushEvent(mkEv(1'b0, 14'h1555, 32'd0, 16'd2000));
      pushEvent(mkEv(1'b0, 14'h1555, 32'd0, 16'd2000));
      busWrite(A_CTRL, 32'h1);
      tick(30);
      checkOutput("t6_mid_pulse", {18'd0, dat_a_o}, {18'd0, 14'h1555});
      busWrite(A_CTRL, 32'h3);
      tick(1);
      checkOutput("t6_clear_a", {18'd0, dat_a_o}, {18'd0, curBase});
      checkOutput("t6_clear_b", {18'd0, dat_b_o}, {18'd0, curBase});
      modelClear();
      checkStats("t6_clear");
      busRead(A_CTRL, r);
      checkOutput("t6_enable_kept", r, 32'h1);
      busWrite(A_CTRL, 32'h0);

      // Back-to-back zero-gap pulses.
      pushEvent(mkEv(1'b0, 14'h0AAA, 32'd0, 16'd1));
      pushEvent(mkEv(1'b0, 14'h0AAA, 32'd0, 16'd1));
      startRun(2);
      finishRun("t4");
      checkStats("t4_post");

      // Enable dropped mid-pulse: pulse completes, second event stays queued.
      pushEvent(mkEv(1'b1, 14'h2222, 32'd0, 16'd100));
      pushEvent(mkEv(1'b0, 14'h0333, 32'd0, 16'd5));
      startRun(1);
      tick(20);
      busWrite(A_CTRL, 32'h0);
      finishRun("t5");
      checkStats("t5_post");

      for (int round = 0; round < 8; round++) begin
         doClear();
         setBase(14'($urandom));
         k = $urandom_range(1, 5);
         for (int i = 0; i < k; i++)
            pushEvent(mkEv(1'($urandom), 14'($urandom), 32'($urandom_range(0, 6)),
                           16'($urandom_range(0, 5))));
         startRun(k);
         finishRun($sformatf("rnd%0d", round));
         checkStats($sformatf("rnd%0d", round));
      end

      // Asynchronous reset in the middle of a pulse.
      doClear();
      pushEvent(mkEv(1'b1, 14'h0777, 32'd0, 16'd3000));
      busWrite(A_CTRL, 32'h1);
      tick(10);
      checkOutput("t6_pre_rst", {18'd0, dat_b_o}, {18'd0, 14'h0777});
      #2 rstn_i = 1'b0;
      #1;
      checkOutput("t6_rst_a", {18'd0, dat_a_o}, 32'd0);
      checkOutput("t6_rst_b", {18'd0, dat_b_o}, 32'd0);
      @(negedge clk_i);
      rstn_i = 1'b1;
      tick(1);
      modelClear();
      curBase = 14'd0;
      checkStats("t6_rst");
      busRead(A_BASE, r);
      checkOutput("t6_rst_base", r, 32'd0);
      busRead(A_CTRL, r);
      checkOutput("t6_rst_ctrl", r, 32'd0);

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
